// File: rtl/apb_wait_completer_pkg.sv
// Shared types and defaults for the APB wait-state completer.
// Holds the FSM state encoding and the saturating error-count helper.
package apb_wait_completer_pkg;

  localparam int DATAWIDTH_DEF = 8;
  localparam int ADDRWIDTH_DEF = 8;
  localparam int MEM_DEPTH_DEF = 64;
  localparam int WAITWIDTH_DEF = 4;
  localparam int ERRCNT_W      = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (v == '1) ? v : v + ERRCNT_W'(1);
  endfunction

endpackage

// File: rtl/apb_wait_completer_if.sv
// APB3 completer-side bus bundle; PADDR carries the bridge slave-select in its top bit.
// The master modport drives the request, the slave modport returns PRDATA/PREADY/PSLVERR.
interface apb_wait_completer_if
  import apb_wait_completer_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int ADDRWIDTH = ADDRWIDTH_DEF
);
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDRWIDTH:0]   PADDR;
  logic [DATAWIDTH-1:0] PWDATA;
  logic [DATAWIDTH-1:0] PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_wait_completer.sv
// APB3 completer with byte-wide register memory, programmable wait states and PSLVERR.
// PREADY rises in access cycle wait_cycles+1; PSEL dropped while waiting aborts without side effects.
module apb_wait_completer
  import apb_wait_completer_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int ADDRWIDTH = ADDRWIDTH_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int WAITWIDTH = WAITWIDTH_DEF
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_wait_completer_if.slave  bus,
  input  logic [WAITWIDTH-1:0] wait_cycles,
  output logic [ERRCNT_W-1:0]  err_count
);

  localparam int IDXW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_t               state, state_nxt;
  logic [IDXW-1:0]      offset, offset_nxt;
  logic                 is_write, is_write_nxt;
  logic                 err, err_nxt;
  logic [WAITWIDTH-1:0] cnt, cnt_nxt;
  logic                 ready, ready_nxt;
  logic                 slverr, slverr_nxt;
  logic [DATAWIDTH-1:0] rdata, rdata_nxt;
  logic [ERRCNT_W-1:0]  err_cnt_q, err_cnt_nxt;
  logic                 mem_we;
  logic [DATAWIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDRWIDTH-1:0] setup_off;
  logic                 setup_err;

  assign setup_off = bus.PADDR[ADDRWIDTH-1:0];
  assign setup_err = (int'(setup_off) >= MEM_DEPTH);

  always_comb begin
    state_nxt    = state;
    offset_nxt   = offset;
    is_write_nxt = is_write;
    err_nxt      = err;
    cnt_nxt      = cnt;
    ready_nxt    = ready;
    slverr_nxt   = slverr;
    rdata_nxt    = rdata;
    err_cnt_nxt  = err_cnt_q;
    mem_we       = 1'b0;

    case (state)
      ST_IDLE: begin
        // PENABLE already high here is a protocol violation and is ignored
        if (bus.PSEL && !bus.PENABLE) begin
          state_nxt    = ST_ACCESS;
          offset_nxt   = setup_off[IDXW-1:0];
          is_write_nxt = bus.PWRITE;
          err_nxt      = setup_err;
          cnt_nxt      = wait_cycles;
          if (wait_cycles == '0) begin
            ready_nxt  = 1'b1;
            slverr_nxt = setup_err;
            rdata_nxt  = (!bus.PWRITE && !setup_err) ? mem[setup_off[IDXW-1:0]] : '0;
          end
        end
      end
      ST_ACCESS: begin
        if (!ready) begin
          if (!bus.PSEL) begin
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt - WAITWIDTH'(1);
            if (cnt == WAITWIDTH'(1)) begin
              ready_nxt  = 1'b1;
              slverr_nxt = err;
              rdata_nxt  = (!is_write && !err) ? mem[offset] : '0;
            end
          end
        end else begin
          mem_we = is_write && !err;
          if (err) err_cnt_nxt = sat_inc(err_cnt_q);
          ready_nxt  = 1'b0;
          slverr_nxt = 1'b0;
          rdata_nxt  = '0;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= ST_IDLE;
      offset    <= '0;
      is_write  <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      ready     <= 1'b0;
      slverr    <= 1'b0;
      rdata     <= '0;
      err_cnt_q <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      state     <= state_nxt;
      offset    <= offset_nxt;
      is_write  <= is_write_nxt;
      err       <= err_nxt;
      cnt       <= cnt_nxt;
      ready     <= ready_nxt;
      slverr    <= slverr_nxt;
      rdata     <= rdata_nxt;
      err_cnt_q <= err_cnt_nxt;
      if (mem_we) mem[offset] <= bus.PWDATA;
    end
  end

  assign bus.PREADY  = ready;
  assign bus.PSLVERR = slverr;
  assign bus.PRDATA  = rdata;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_apb_wait_completer.sv
// Directed bench for apb_wait_completer: transfer-level model plus a per-cycle output checker.
module tb_apb_wait_completer;

  localparam int MEM_DEPTH = 64;

  logic       clk;
  logic       rst;
  logic [3:0] wc;
  logic [7:0] ec;

  apb_wait_completer_if #(.DATAWIDTH(8), .ADDRWIDTH(8)) bus ();

  apb_wait_completer dut (
    .PCLK        (clk),
    .PRESET      (rst),
    .bus         (bus),
    .wait_cycles (wc),
    .err_count   (ec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_mem [0:255];
  int         model_errcnt;

  logic       chk_en = 1'b0;
  logic       exp_ready;
  logic       exp_slverr;
  logic [7:0] exp_rdata;
  logic [7:0] exp_errcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // outputs are stable between edges; compare at the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("pready",    32'(bus.PREADY),  32'(exp_ready));
      check("pslverr",   32'(bus.PSLVERR), 32'(exp_slverr));
      check("prdata",    32'(bus.PRDATA),  32'(exp_rdata));
      check("err_count", 32'(ec),          32'(exp_errcnt));
    end
  end

  task automatic set_exp(input logic r, input logic s, input logic [7:0] d);
    exp_ready  = r;
    exp_slverr = s;
    exp_rdata  = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    model_errcnt = 0;
    exp_errcnt   = 8'h00;
  endtask

  task automatic idle(input int n);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    set_exp(1'b0, 1'b0, 8'h00);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One full transfer; setup cycle starts now, returns just after the completion edge.
  task automatic xfer(input logic wr, input logic [8:0] addr, input logic [7:0] wd,
                      input logic [3:0] w, output logic [7:0] rd, output logic se,
                      output int lat);
    logic [7:0] off;
    logic       e;
    logic [7:0] erd;
    off = addr[7:0];
    e   = (int'(off) >= MEM_DEPTH);
    erd = (!wr && !e) ? model_mem[off] : 8'h00;
    lat = 0;
    rd  = 8'h00;
    se  = 1'b0;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wd;
    wc          = w;
    set_exp(1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    bus.PADDR   = ~addr;
    wc          = ~w;
    for (int k = 1; k <= int'(w) + 1; k++) begin
      if (k == int'(w) + 1) set_exp(1'b1, e, erd);
      else                  set_exp(1'b0, 1'b0, 8'h00);
      if (bus.PREADY === 1'b1 && lat == 0) begin
        lat = k;
        rd  = bus.PRDATA;
        se  = bus.PSLVERR;
      end
      @(posedge clk); #1;
    end
    if (wr && !e) model_mem[off] = wd;
    if (e && model_errcnt < 255) model_errcnt++;
    exp_errcnt = 8'(model_errcnt);
    set_exp(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       se;
    int         lat;

    rst         = 1'b1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    wc          = 4'd0;
    model_reset();
    set_exp(1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset_pready", 32'(bus.PREADY), 32'h0);
    check("reset_errcnt", 32'(ec), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // 1) zero-wait write then read, slave-select bit set in PADDR
    xfer(1'b1, 9'h110, 8'hA5, 4'd0, rd, se, lat);
    check("t1_wr_lat", 32'(lat), 32'd1);
    xfer(1'b0, 9'h110, 8'h00, 4'd0, rd, se, lat);
    check("t1_rd_data", 32'(rd), 32'hA5);
    check("t1_rd_err", 32'(se), 32'h0);
    check("t1_rd_lat", 32'(lat), 32'd1);

    // 2) three wait states: ready on 4th access cycle
    xfer(1'b0, 9'h010, 8'h00, 4'd3, rd, se, lat);
    check("t2_lat", 32'(lat), 32'd4);
    check("t2_data", 32'(rd), 32'hA5);

    // PENABLE high while idle is ignored
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 9'h010; bus.PWDATA = 8'hEE;
    set_exp(1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    idle(1);
    xfer(1'b0, 9'h010, 8'h00, 4'd1, rd, se, lat);
    check("penable_idle_data", 32'(rd), 32'hA5);

    // 3) out-of-range write and read
    xfer(1'b1, 9'h050, 8'h3C, 4'd0, rd, se, lat);
    check("t3_wr_err", 32'(se), 32'h1);
    check("t3_errcnt", 32'(ec), 32'd1);
    xfer(1'b0, 9'h050, 8'h00, 4'd2, rd, se, lat);
    check("t3_rd_data", 32'(rd), 32'h0);
    check("t3_rd_err", 32'(se), 32'h1);
    idle(1);

    // 4) reset during 2nd wait cycle of a write to 0x05
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 9'h005; bus.PWDATA = 8'h99;
    wc = 4'd3;
    set_exp(1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle(2);
    check("t4_errcnt", 32'(ec), 32'h0);
    xfer(1'b0, 9'h005, 8'h00, 4'd0, rd, se, lat);
    check("t4_mem05", 32'(rd), 32'h0);

    // 5) abort mid-wait, then a fresh write to the same offset
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 9'h001; bus.PWDATA = 8'h11;
    wc = 4'd3;
    set_exp(1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    idle(2);
    xfer(1'b0, 9'h001, 8'h00, 4'd0, rd, se, lat);
    check("t5_abort_nocommit", 32'(rd), 32'h0);
    xfer(1'b1, 9'h001, 8'h77, 4'd1, rd, se, lat);
    xfer(1'b0, 9'h001, 8'h00, 4'd0, rd, se, lat);
    check("t5_data", 32'(rd), 32'h77);

    // maximum wait count
    xfer(1'b0, 9'h001, 8'h00, 4'd15, rd, se, lat);
    check("wmax_lat", 32'(lat), 32'd16);
    check("wmax_data", 32'(rd), 32'h77);

    // 6) error counter saturation, back-to-back
    for (int i = 0; i < 300; i++)
      xfer(1'(i), 9'(64 + (i % 192)), 8'(i), 4'(i % 2), rd, se, lat);
    check("t6_errcnt_sat", 32'(ec), 32'd255);

    // back-to-back fill of the whole memory, then read back
    for (int i = 0; i < MEM_DEPTH; i++)
      xfer(1'b1, 9'(i), 8'(i * 7 + 3), 4'(i % 3), rd, se, lat);
    for (int i = 0; i < MEM_DEPTH; i++)
      xfer(1'b0, 9'(i), 8'h00, 4'(i % 2), rd, se, lat);
    check("t6_last_word", 32'(rd), 32'((63 * 7 + 3) % 256));
    check("t6_errcnt_hold", 32'(ec), 32'd255);
    idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
